// File: rtl/pl_stall_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pl_pkg -- shared definitions for the pipeline stall/flush controller.
//   mem_state_e      : data-memory handshake FSM states
//   FWD_RF/FWD_M/FWD_W : forward-select codes driven to the E-stage operand muxes
//   RESULT_SRC_LOAD  : result_src_e encoding that marks a load in E
// -----------------------------------------------------------------------------
package pl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_WAIT = 2'b01,
    ST_ERR  = 2'b10
  } mem_state_e;

  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_M  = 2'b10;
  localparam logic [1:0] FWD_W  = 2'b01;

  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;

endpackage

// File: rtl/pl_stall_ctrl_if.sv
// -----------------------------------------------------------------------------
// pl_stall_ctrl_if -- bundle between the pipeline datapath and the stall
// controller.
//   master : pipeline side; drives register indices, control bits and the
//            memory handshake, receives stall/flush/forward controls.
//   slave  : controller side (pl_stall_ctrl).
// -----------------------------------------------------------------------------
interface pl_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [4:0]       rs1_d, rs2_d;
  logic [4:0]       rs1_e, rs2_e;
  logic [4:0]       rd_e, rd_m, rd_w;
  logic [1:0]       result_src_e;
  logic             reg_write_m, reg_write_w;
  logic             pc_src_e;
  logic             mem_req_m, mem_ack;
  logic             stall_f, stall_d, stall_e, stall_m;
  logic             flush_d, flush_e, flush_w;
  logic [1:0]       forward_a_e, forward_b_e;
  logic             mem_err;
  logic [CNT_W-1:0] stall_cycles;

  modport master (
    output rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    output result_src_e, reg_write_m, reg_write_w, pc_src_e,
    output mem_req_m, mem_ack,
    input  stall_f, stall_d, stall_e, stall_m,
    input  flush_d, flush_e, flush_w,
    input  forward_a_e, forward_b_e, mem_err, stall_cycles
  );

  modport slave (
    input  rs1_d, rs2_d, rs1_e, rs2_e, rd_e, rd_m, rd_w,
    input  result_src_e, reg_write_m, reg_write_w, pc_src_e,
    input  mem_req_m, mem_ack,
    output stall_f, stall_d, stall_e, stall_m,
    output flush_d, flush_e, flush_w,
    output forward_a_e, forward_b_e, mem_err, stall_cycles
  );
endinterface

// File: rtl/pl_stall_ctrl_fwd_unit.sv
// -----------------------------------------------------------------------------
// fwd_unit -- operand forwarding select for one E-stage source register.
//   rs_e_i          : E-stage source index
//   rd_m_i, rd_w_i  : M / W destination indices
//   reg_write_m_i/w_i : M / W write enables
//   fwd_sel_o       : FWD_M, FWD_W or FWD_RF (M has priority, x0 never forwarded)
// -----------------------------------------------------------------------------
module fwd_unit
  import pl_pkg::*;
(
  input  logic [4:0] rs_e_i,
  input  logic [4:0] rd_m_i,
  input  logic [4:0] rd_w_i,
  input  logic       reg_write_m_i,
  input  logic       reg_write_w_i,
  output logic [1:0] fwd_sel_o
);

  // Priority select: the younger M result wins over W.
  always_comb begin
    fwd_sel_o = FWD_RF;
    if (reg_write_m_i && (rd_m_i != 5'd0) && (rd_m_i == rs_e_i)) begin
      fwd_sel_o = FWD_M;
    end else if (reg_write_w_i && (rd_w_i != 5'd0) && (rd_w_i == rs_e_i)) begin
      fwd_sel_o = FWD_W;
    end else begin
      fwd_sel_o = FWD_RF;
    end
  end

endmodule

// File: rtl/pl_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pl_stall_ctrl -- hazard unit for a 5-stage pipeline.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : pl_stall_ctrl_if.slave (indices, control, memory handshake in;
//                stall/flush/forward controls, mem_err, stall_cycles out)
// Stalls/flushes/forwards are combinational. A memory stall freezes the whole
// front of the pipe and bubbles W; it overrides load-use and branch handling.
// A memory access that sees no ack for MEM_TIMEOUT cycles (MEM_TIMEOUT >= 2)
// parks the FSM in ERR until reset.
// -----------------------------------------------------------------------------
module pl_stall_ctrl
  import pl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  pl_stall_ctrl_if.slave  bus
);

  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  // Last WAIT count before the timeout: the IDLE miss cycle plus WAIT counts
  // 0..MEM_TIMEOUT-2 add up to MEM_TIMEOUT unacknowledged cycles.
  localparam logic [TO_W-1:0] WAIT_LAST = TO_W'(MEM_TIMEOUT - 2);

  mem_state_e       state_q, state_d;
  logic [TO_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             mem_stall_s;
  logic             lw_stall_s;
  logic             stall_fd_s, stall_em_s;
  logic             flush_d_s, flush_e_s, flush_w_s;

  fwd_unit u_fwd_a (
    .rs_e_i        (bus.rs1_e),
    .rd_m_i        (bus.rd_m),
    .rd_w_i        (bus.rd_w),
    .reg_write_m_i (bus.reg_write_m),
    .reg_write_w_i (bus.reg_write_w),
    .fwd_sel_o     (bus.forward_a_e)
  );

  fwd_unit u_fwd_b (
    .rs_e_i        (bus.rs2_e),
    .rd_m_i        (bus.rd_m),
    .rd_w_i        (bus.rd_w),
    .reg_write_m_i (bus.reg_write_m),
    .reg_write_w_i (bus.reg_write_w),
    .fwd_sel_o     (bus.forward_b_e)
  );

  // Memory FSM state, wait counter and stall-cycle counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      wait_cnt_q  <= {TO_W{1'b0}};
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Memory FSM next state and the combinational memory-stall request.
  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    mem_stall_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_req_m && !bus.mem_ack) begin
          state_d     = ST_WAIT;
          wait_cnt_d  = {TO_W{1'b0}};
          mem_stall_s = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (bus.mem_ack) begin
          state_d = ST_IDLE;
        end else begin
          mem_stall_s = 1'b1;
          if (wait_cnt_q == WAIT_LAST) begin
            state_d = ST_ERR;
          end else begin
            wait_cnt_d = wait_cnt_q + TO_W'(1);
          end
        end
      end
      ST_ERR: begin
        mem_stall_s = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Load-use hazard; a taken branch in E squashes the dependent D instruction
  // anyway, so no stall is needed then.
  assign lw_stall_s = (bus.result_src_e == RESULT_SRC_LOAD) && (bus.rd_e != 5'd0) &&
                      ((bus.rd_e == bus.rs1_d) || (bus.rd_e == bus.rs2_d)) &&
                      !bus.pc_src_e;

  // Stall/flush arbitration: a memory stall holds everything and masks
  // branch/load-use flushes until the ack cycle.
  always_comb begin
    stall_fd_s = 1'b0;
    stall_em_s = 1'b0;
    flush_d_s  = 1'b0;
    flush_e_s  = 1'b0;
    flush_w_s  = 1'b0;
    if (mem_stall_s) begin
      stall_fd_s = 1'b1;
      stall_em_s = 1'b1;
      flush_w_s  = 1'b1;
    end else begin
      stall_fd_s = lw_stall_s;
      flush_d_s  = bus.pc_src_e;
      flush_e_s  = lw_stall_s || bus.pc_src_e;
    end
  end

  // Saturating count of cycles in which fetch is held.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_fd_s && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  assign bus.stall_f      = stall_fd_s;
  assign bus.stall_d      = stall_fd_s;
  assign bus.stall_e      = stall_em_s;
  assign bus.stall_m      = stall_em_s;
  assign bus.flush_d      = flush_d_s;
  assign bus.flush_e      = flush_e_s;
  assign bus.flush_w      = flush_w_s;
  assign bus.mem_err      = (state_q == ST_ERR);
  assign bus.stall_cycles = stall_cnt_q;

endmodule
